// File: rtl/vec_mem_arbiter.sv
// Shares one 32-bit valid/ready memory port between the picorv32 core and picorv32_pcpi_vec.
// Vector-preferred with a bounded CPU wait; `define ARB_STATS_EN builds grant/conflict counters.
module vec_mem_arbiter #(
    parameter int unsigned VEC_BURST_MAX = 4,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cpu_valid,
    input  logic             cpu_instr,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    input  logic [3:0]       cpu_wstrb,
    output logic             cpu_ready,
    output logic [31:0]      cpu_rdata,
    input  logic             vec_valid,
    input  logic [31:0]      vec_addr,
    input  logic [31:0]      vec_wdata,
    input  logic [3:0]       vec_wstrb,
    output logic             vec_ready,
    output logic [31:0]      vec_rdata,
    output logic             m_valid,
    output logic             m_instr,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_wdata,
    output logic [3:0]       m_wstrb,
    input  logic             m_ready,
    input  logic [31:0]      m_rdata,
    output logic [CNT_W-1:0] stat_cpu_grants,
    output logic [CNT_W-1:0] stat_vec_grants,
    output logic [CNT_W-1:0] stat_conflicts
);

    localparam int unsigned STREAK_W = $clog2(VEC_BURST_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(VEC_BURST_MAX);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e              r_state, w_state_next;
    logic                r_gnt_cpu, w_gnt_cpu_next;
    logic [STREAK_W-1:0] r_streak, w_streak_next;
    logic                r_m_valid, w_m_valid_next;
    logic                r_m_instr, w_m_instr_next;
    logic [31:0]         r_m_addr, w_m_addr_next;
    logic [31:0]         r_m_wdata, w_m_wdata_next;
    logic [3:0]          r_m_wstrb, w_m_wstrb_next;
    logic                r_cpu_ready, w_cpu_ready_next;
    logic [31:0]         r_cpu_rdata, w_cpu_rdata_next;
    logic                r_vec_ready, w_vec_ready_next;
    logic [31:0]         r_vec_rdata, w_vec_rdata_next;

    logic w_grant_cpu;
    logic w_grant_vec;

    // Only meaningful in StIdle; the CPU wins a conflict once the vector streak hits the limit.
    assign w_grant_cpu = cpu_valid & (~vec_valid | (r_streak >= STREAK_MAX));
    assign w_grant_vec = vec_valid & ~w_grant_cpu;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= StIdle;
            r_gnt_cpu   <= 1'b0;
            r_streak    <= '0;
            r_m_valid   <= 1'b0;
            r_m_instr   <= 1'b0;
            r_m_addr    <= '0;
            r_m_wdata   <= '0;
            r_m_wstrb   <= '0;
            r_cpu_ready <= 1'b0;
            r_cpu_rdata <= '0;
            r_vec_ready <= 1'b0;
            r_vec_rdata <= '0;
        end else begin
            r_state     <= w_state_next;
            r_gnt_cpu   <= w_gnt_cpu_next;
            r_streak    <= w_streak_next;
            r_m_valid   <= w_m_valid_next;
            r_m_instr   <= w_m_instr_next;
            r_m_addr    <= w_m_addr_next;
            r_m_wdata   <= w_m_wdata_next;
            r_m_wstrb   <= w_m_wstrb_next;
            r_cpu_ready <= w_cpu_ready_next;
            r_cpu_rdata <= w_cpu_rdata_next;
            r_vec_ready <= w_vec_ready_next;
            r_vec_rdata <= w_vec_rdata_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_gnt_cpu_next   = r_gnt_cpu;
        w_streak_next    = r_streak;
        w_m_valid_next   = r_m_valid;
        w_m_instr_next   = r_m_instr;
        w_m_addr_next    = r_m_addr;
        w_m_wdata_next   = r_m_wdata;
        w_m_wstrb_next   = r_m_wstrb;
        w_cpu_ready_next = 1'b0;
        w_cpu_rdata_next = r_cpu_rdata;
        w_vec_ready_next = 1'b0;
        w_vec_rdata_next = r_vec_rdata;

        unique case (r_state)
            StIdle: begin
                if (!cpu_valid) begin
                    w_streak_next = '0;
                end
                if (w_grant_cpu) begin
                    w_state_next   = StBusy;
                    w_gnt_cpu_next = 1'b1;
                    w_streak_next  = '0;
                    w_m_valid_next = 1'b1;
                    w_m_instr_next = cpu_instr;
                    w_m_addr_next  = cpu_addr;
                    w_m_wdata_next = cpu_wdata;
                    w_m_wstrb_next = cpu_wstrb;
                end else if (w_grant_vec) begin
                    w_state_next   = StBusy;
                    w_gnt_cpu_next = 1'b0;
                    w_m_valid_next = 1'b1;
                    w_m_instr_next = 1'b0;
                    w_m_addr_next  = vec_addr;
                    w_m_wdata_next = vec_wdata;
                    w_m_wstrb_next = vec_wstrb;
                    if (cpu_valid && (r_streak != STREAK_MAX)) begin
                        w_streak_next = r_streak + STREAK_W'(1);
                    end
                end
            end
            StBusy: begin
                if (m_ready) begin
                    w_state_next   = StResp;
                    w_m_valid_next = 1'b0;
                    if (r_gnt_cpu) begin
                        w_cpu_ready_next = 1'b1;
                        w_cpu_rdata_next = m_rdata;
                    end else begin
                        w_vec_ready_next = 1'b1;
                        w_vec_rdata_next = m_rdata;
                    end
                end
            end
            // Requesters see ready during this cycle and may drop valid; ignore them.
            StResp: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign cpu_ready = r_cpu_ready;
    assign cpu_rdata = r_cpu_rdata;
    assign vec_ready = r_vec_ready;
    assign vec_rdata = r_vec_rdata;
    assign m_valid   = r_m_valid;
    assign m_instr   = r_m_instr;
    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;
    assign m_wstrb   = r_m_wstrb;

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] r_stat_cpu;
    logic [CNT_W-1:0] r_stat_vec;
    logic [CNT_W-1:0] r_stat_conf;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stat_cpu  <= '0;
            r_stat_vec  <= '0;
            r_stat_conf <= '0;
        end else if (r_state == StIdle) begin
            if (w_grant_cpu) begin
                r_stat_cpu <= r_stat_cpu + CNT_W'(1);
            end
            if (w_grant_vec) begin
                r_stat_vec <= r_stat_vec + CNT_W'(1);
            end
            if (cpu_valid && vec_valid) begin
                r_stat_conf <= r_stat_conf + CNT_W'(1);
            end
        end
    end

    assign stat_cpu_grants = r_stat_cpu;
    assign stat_vec_grants = r_stat_vec;
    assign stat_conflicts  = r_stat_conf;
`else
    assign stat_cpu_grants = '0;
    assign stat_vec_grants = '0;
    assign stat_conflicts  = '0;
`endif

endmodule
